// File: rtl/agnus_blitter_shiftseq_pkg.sv
// Shared definitions for the blitter A/B shift sequencer.
package agnus_blitter_shiftseq_pkg;

  localparam int WBITS_DEF = 6;
  localparam int HBITS_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // First/last-word masks only ever apply to channel A.
  function automatic logic [15:0] apply_masks(input logic [15:0] a,
                                              input logic [15:0] afwm,
                                              input logic [15:0] alwm,
                                              input logic        first,
                                              input logic        last);
    return a & (first ? afwm : 16'hFFFF) & (last ? alwm : 16'hFFFF);
  endfunction

endpackage

// File: rtl/agnus_blitter_shiftseq_if.sv
// Configuration, source-word and result signals of the shift sequencer.
interface agnus_blitter_shiftseq_if #(
  parameter int WBITS = agnus_blitter_shiftseq_pkg::WBITS_DEF,
  parameter int HBITS = agnus_blitter_shiftseq_pkg::HBITS_DEF
);
  logic             start;
  logic             desc;
  logic [3:0]       ash;
  logic [3:0]       bsh;
  logic [WBITS-1:0] width;
  logic [HBITS-1:0] height;
  logic [15:0]      afwm;
  logic [15:0]      alwm;
  logic             word_valid;
  logic             word_ready;
  logic [15:0]      a_data;
  logic [15:0]      b_data;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      sa;
  logic [15:0]      sb;
  logic             out_first;
  logic             out_last;
  logic             busy;
  logic             done;

  // Driver side: DMA fetch / configuration and the downstream consumer.
  modport master (
    output start, desc, ash, bsh, width, height, afwm, alwm,
           word_valid, a_data, b_data, out_ready,
    input  word_ready, out_valid, sa, sb, out_first, out_last, busy, done
  );

  // Sequencer side.
  modport slave (
    input  start, desc, ash, bsh, width, height, afwm, alwm,
           word_valid, a_data, b_data, out_ready,
    output word_ready, out_valid, sa, sb, out_first, out_last, busy, done
  );
endinterface

// File: rtl/agnus_blitter_barrelshifter.sv
// 16-bit funnel shifter: shifts the new word and fills vacated bits from
// the previous word of the same channel. Shift 0 passes the new word.
module agnus_blitter_barrelshifter (
  input  logic        desc,
  input  logic [3:0]  shift,
  input  logic [15:0] new_word,
  input  logic [15:0] old_word,
  output logic [15:0] out
);

  // Ascending takes the low half of {old,new}>>n, descending the high
  // half of {new,old}<<n; both collapse to new_word for n = 0.
  always_comb begin
    if (desc)
      out = 16'(({new_word, old_word} << shift) >> 16);
    else
      out = 16'({old_word, new_word} >> shift);
  end

endmodule

// File: rtl/agnus_blitter_shiftseq_cnt.sv
// Width/height down-counters with first/last/end-of-blit decode.
// A field value of 0 expands to 2^N.
module agnus_blitter_shiftseq_cnt #(
  parameter int WBITS = 6,
  parameter int HBITS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WBITS-1:0] width,
  input  logic [HBITS-1:0] height,
  output logic             first,
  output logic             last,
  output logic             end_blit
);

  logic [WBITS:0] width_in, weff, wcnt;
  logic [HBITS:0] height_in, hcnt;

  assign width_in  = (width  == '0) ? {1'b1, {WBITS{1'b0}}} : {1'b0, width};
  assign height_in = (height == '0) ? {1'b1, {HBITS{1'b0}}} : {1'b0, height};

  assign first    = (wcnt == weff);
  assign last     = (wcnt == (WBITS+1)'(1));
  assign end_blit = last && (hcnt == (HBITS+1)'(1));

  // Load on start; each accepted word steps the word counter, the last
  // word of a row reloads it and steps the row counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      weff <= '0;
      wcnt <= '0;
      hcnt <= '0;
    end else if (load) begin
      weff <= width_in;
      wcnt <= width_in;
      hcnt <= height_in;
    end else if (step) begin
      if (last) begin
        wcnt <= weff;
        hcnt <= hcnt - 1'b1;
      end else begin
        wcnt <= wcnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/agnus_blitter_shiftseq.sv
// Blitter A/B shift-path word sequencer: walks a width x height blit,
// masks and shifts each accepted A/B pair and registers the result.
module agnus_blitter_shiftseq
  import agnus_blitter_shiftseq_pkg::*;
#(
  parameter int WBITS = WBITS_DEF,
  parameter int HBITS = HBITS_DEF
) (
  input logic                   clk,
  input logic                   reset,
  agnus_blitter_shiftseq_if.slave bus
);

  state_t      state;
  logic        desc_q;
  logic [3:0]  ash_q, bsh_q;
  logic [15:0] afwm_q, alwm_q;
  logic [15:0] old_a, old_b;
  logic        out_valid_q, out_first_q, out_last_q;
  logic [15:0] sa_q, sb_q;
  logic        busy_q, done_q;

  logic        word_ready_c, accept, load;
  logic        first, last, end_blit;
  logic [15:0] ma, sa_n, sb_n;

  // The output register can take a new word when empty or being drained.
  assign word_ready_c = (state == ST_RUN) && (!out_valid_q || bus.out_ready);
  assign accept       = bus.word_valid && word_ready_c;
  assign load         = (state == ST_IDLE) && bus.start;

  agnus_blitter_shiftseq_cnt #(.WBITS(WBITS), .HBITS(HBITS)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .step     (accept),
    .width    (bus.width),
    .height   (bus.height),
    .first    (first),
    .last     (last),
    .end_blit (end_blit)
  );

  assign ma = apply_masks(bus.a_data, afwm_q, alwm_q, first, last);

  agnus_blitter_barrelshifter u_shift_a (
    .desc     (desc_q),
    .shift    (ash_q),
    .new_word (ma),
    .old_word (old_a),
    .out      (sa_n)
  );

  agnus_blitter_barrelshifter u_shift_b (
    .desc     (desc_q),
    .shift    (bsh_q),
    .new_word (bus.b_data),
    .old_word (old_b),
    .out      (sb_n)
  );

  // Sequencer FSM with registered result, status and done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      desc_q      <= 1'b0;
      ash_q       <= '0;
      bsh_q       <= '0;
      afwm_q      <= '0;
      alwm_q      <= '0;
      old_a       <= '0;
      old_b       <= '0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      sa_q        <= '0;
      sb_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            desc_q <= bus.desc;
            ash_q  <= bus.ash;
            bsh_q  <= bus.bsh;
            afwm_q <= bus.afwm;
            alwm_q <= bus.alwm;
            old_a  <= '0;
            old_b  <= '0;
            busy_q <= 1'b1;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept) begin
            // Reload straight over a consumed word: no bubble.
            out_valid_q <= 1'b1;
            sa_q        <= sa_n;
            sb_q        <= sb_n;
            out_first_q <= first;
            out_last_q  <= last;
            // Old words carry across row boundaries within a blit.
            old_a       <= ma;
            old_b       <= bus.b_data;
            if (end_blit) state <= ST_DRAIN;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.word_ready = word_ready_c;
  assign bus.out_valid  = out_valid_q;
  assign bus.sa         = sa_q;
  assign bus.sb         = sb_q;
  assign bus.out_first  = out_first_q;
  assign bus.out_last   = out_last_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_agnus_blitter_shiftseq.sv
// Directed bench for the blitter shift sequencer.
module tb_agnus_blitter_shiftseq;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  agnus_blitter_shiftseq_if #(.WBITS(6), .HBITS(10)) bus();

  agnus_blitter_shiftseq #(.WBITS(6), .HBITS(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  logic [33:0] res_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Record every consumed result and every done pulse.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.out_valid && bus.out_ready)
        res_q.push_back({bus.out_first, bus.out_last, bus.sa, bus.sb});
      if (bus.done) done_cnt++;
    end
  end

  task automatic start_blit(input logic d, input logic [3:0] ash, input logic [3:0] bsh,
                            input logic [5:0] w, input logic [9:0] h,
                            input logic [15:0] fm, input logic [15:0] lm);
    @(posedge clk); #1;
    bus.desc = d; bus.ash = ash; bus.bsh = bsh; bus.width = w; bus.height = h;
    bus.afwm = fm; bus.alwm = lm; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b);
    bit ok = 0;
    bus.word_valid = 1'b1; bus.a_data = a; bus.b_data = b;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (bus.word_ready) begin
        @(posedge clk); #1;
        ok = 1;
      end
    end
    if (!ok) chk("send_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int d0);
    for (int t = 0; t < 500 && done_cnt == d0; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic chk_word(input string tag, input int i, input logic [15:0] esa,
                          input logic [15:0] esb, input logic ef, input logic el);
    logic [33:0] r;
    if (i < res_q.size()) begin
      r = res_q[i];
      chk($sformatf("%s_sa%0d", tag, i), 32'(r[31:16]), 32'(esa));
      chk($sformatf("%s_sb%0d", tag, i), 32'(r[15:0]), 32'(esb));
      chk($sformatf("%s_fl%0d", tag, i), 32'(r[33:32]), 32'({ef, el}));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int base, d0;
    logic [33:0] snap;
    logic [15:0] t4_sa [8];
    t4_sa = '{16'h0111, 16'h1222, 16'h2333, 16'h3444,
              16'h4555, 16'h5666, 16'h6777, 16'h7888};

    bus.start = 0; bus.desc = 0; bus.ash = 0; bus.bsh = 0; bus.width = 0;
    bus.height = 0; bus.afwm = 0; bus.alwm = 0; bus.word_valid = 0;
    bus.a_data = 0; bus.b_data = 0; bus.out_ready = 1;

    // Reset state
    repeat (3) @(posedge clk); #1;
    chk("rst_ctl", 32'({bus.word_ready, bus.out_valid, bus.out_first, bus.out_last,
                        bus.busy, bus.done}), 32'd0);
    chk("rst_data", {bus.sa, bus.sb}, 32'd0);
    reset = 1'b0;

    // Ascending shift, B shifted by 8
    base = res_q.size(); d0 = done_cnt;
    start_blit(1'b0, 4'd4, 4'd8, 6'd2, 10'd1, 16'hFFFF, 16'hFFFF);
    chk("t1_busy_rise", 32'(bus.busy), 32'd1);
    send(16'h1234, 16'hABCD);
    send(16'h5678, 16'h1234);
    bus.word_valid = 0;
    wait_done("t1", d0);
    chk("t1_busy_fall", 32'(bus.busy), 32'd0);
    chk("t1_count", 32'(res_q.size() - base), 32'd2);
    chk_word("t1", base + 0, 16'h0123, 16'h00AB, 1'b1, 1'b0);
    chk_word("t1", base + 1, 16'h4567, 16'hCD12, 1'b0, 1'b1);

    // Descending shift
    base = res_q.size(); d0 = done_cnt;
    start_blit(1'b1, 4'd4, 4'd4, 6'd2, 10'd1, 16'hFFFF, 16'hFFFF);
    send(16'h1234, 16'hABCD);
    send(16'h5678, 16'h1234);
    bus.word_valid = 0;
    wait_done("t2", d0);
    chk("t2_count", 32'(res_q.size() - base), 32'd2);
    chk_word("t2", base + 0, 16'h2340, 16'hBCD0, 1'b1, 1'b0);
    chk_word("t2", base + 1, 16'h6781, 16'h234A, 1'b0, 1'b1);

    // Single-word row: both masks apply
    base = res_q.size(); d0 = done_cnt;
    start_blit(1'b0, 4'd0, 4'd0, 6'd1, 10'd1, 16'hFF00, 16'h0FF0);
    send(16'hFFFF, 16'h0001);
    bus.word_valid = 0;
    wait_done("t3", d0);
    chk("t3_count", 32'(res_q.size() - base), 32'd1);
    chk_word("t3", base + 0, 16'h0F00, 16'h0001, 1'b1, 1'b1);

    // Backpressure mid-row, two rows
    base = res_q.size(); d0 = done_cnt;
    start_blit(1'b0, 4'd4, 4'd0, 6'd4, 10'd2, 16'hFFFF, 16'hFFFF);
    fork
      begin
        for (int i = 0; i < 8; i++) send(16'(16'h1111 * (i + 1)), 16'(i));
        bus.word_valid = 0;
      end
      begin
        repeat (3) @(posedge clk); #1;
        bus.out_ready = 0;
        @(negedge clk);
        snap = {bus.out_first, bus.out_last, bus.sa, bus.sb};
        chk("t4_hold_valid", 32'(bus.out_valid), 32'd1);
        chk("t4_hold_ready", 32'(bus.word_ready), 32'd0);
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          chk("t4_hold_data", {bus.sa, bus.sb}, snap[31:0]);
          chk("t4_hold_flags", 32'({bus.out_first, bus.out_last, bus.out_valid}),
              32'({snap[33:32], 1'b1}));
          chk("t4_hold_ready", 32'(bus.word_ready), 32'd0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1;
      end
    join
    wait_done("t4", d0);
    chk("t4_count", 32'(res_q.size() - base), 32'd8);
    for (int i = 0; i < 8; i++)
      chk_word("t4", base + i, t4_sa[i], 16'(i), (i % 4) == 0, (i % 4) == 3);

    // width = 0 -> 64 words; stray start pulse during the run
    base = res_q.size(); d0 = done_cnt;
    start_blit(1'b0, 4'd0, 4'd0, 6'd0, 10'd1, 16'hFFFF, 16'hFFFF);
    fork
      begin
        for (int i = 0; i < 64; i++) send(16'(i), 16'hFFFF ^ 16'(i));
        bus.word_valid = 0;
      end
      begin
        repeat (10) @(posedge clk); #1;
        bus.start = 1; bus.width = 6'd1; bus.height = 10'd1;
        @(posedge clk); #1;
        bus.start = 0;
      end
    join
    wait_done("t5", d0);
    chk("t5_count", 32'(res_q.size() - base), 32'd64);
    for (int i = 0; i < 64; i++)
      chk_word("t5", base + i, 16'(i), 16'hFFFF ^ 16'(i), i == 0, i == 63);

    // Reset mid-blit, then a clean blit
    start_blit(1'b0, 4'd0, 4'd0, 6'd6, 10'd1, 16'hFFFF, 16'hFFFF);
    send(16'h0001, 16'h0010);
    send(16'h0002, 16'h0020);
    send(16'h0003, 16'h0030);
    bus.word_valid = 0;
    chk("t6_pre_valid", 32'(bus.out_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_rst_ctl", 32'({bus.word_ready, bus.out_valid, bus.out_first, bus.out_last,
                           bus.busy, bus.done}), 32'd0);
    chk("t6_rst_data", {bus.sa, bus.sb}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    d0 = done_cnt;
    repeat (10) @(negedge clk);
    chk("t6_no_done", 32'(done_cnt - d0), 32'd0);
    base = res_q.size(); d0 = done_cnt;
    start_blit(1'b0, 4'd4, 4'd8, 6'd2, 10'd1, 16'hFFFF, 16'hFFFF);
    send(16'h1234, 16'hABCD);
    send(16'h5678, 16'h1234);
    bus.word_valid = 0;
    wait_done("t6", d0);
    chk("t6_count", 32'(res_q.size() - base), 32'd2);
    chk_word("t6", base + 0, 16'h0123, 16'h00AB, 1'b1, 1'b0);
    chk_word("t6", base + 1, 16'h4567, 16'hCD12, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
